my_div: RTL



---
 rtl/my_fixed_pkg.sv | 15 +
 rtl/my_div_sat.sv | 43 ++++
 rtl/my_div.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/my_fixed_pkg.sv
// Shared fixed-point defaults and FSM state encoding for the Q16.48 arithmetic blocks
// (divider and multiplier).
package my_fixed_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_INT_WIDTH  = 16;
    localparam int DEF_FRAC_WIDTH = DEF_DATA_WIDTH - DEF_INT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/my_div_sat.sv
// Applies the result sign to an unsigned quotient magnitude and saturates it to the
// signed DATA_WIDTH range. Divide-by-zero forces full scale in the direction of the sign.
module my_div_sat #(
    parameter int DATA_WIDTH = 64,
    parameter int MAG_WIDTH  = 112
) (
    input  logic [MAG_WIDTH-1:0]  magnitude,
    input  logic                  sign,
    input  logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  overflow
);

    localparam logic [DATA_WIDTH-1:0] MAX_Q = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_Q = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // The negative range reaches one step further than the positive range.
    localparam logic [MAG_WIDTH-1:0] POS_LIM = {{(MAG_WIDTH-DATA_WIDTH){1'b0}}, MAX_Q};
    localparam logic [MAG_WIDTH-1:0] NEG_LIM = {{(MAG_WIDTH-DATA_WIDTH){1'b0}}, MIN_Q};

    always_comb begin
        q        = '0;
        overflow = 1'b0;
        if (div_by_zero) begin
            q = sign ? MIN_Q : MAX_Q;
        end else if (!sign) begin
            if (magnitude > POS_LIM) begin
                q        = MAX_Q;
                overflow = 1'b1;
            end else begin
                q = magnitude[DATA_WIDTH-1:0];
            end
        end else begin
            if (magnitude > NEG_LIM) begin
                q        = MIN_Q;
                overflow = 1'b1;
            end else begin
                q = -magnitude[DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/my_div.sv
// Signed fixed-point divider: restoring division of |a|*2^FRAC by |b|, one quotient bit
// per clock, followed by sign application and saturation.
module my_div
    import my_fixed_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int INT_WIDTH  = DEF_INT_WIDTH
) (
    input  logic                  ADC_CLK,
    input  logic                  RST,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  div_by_zero,
    output logic                  overflow,
    output logic [1:0]            dbg_state
);

    localparam int FRAC_WIDTH = DATA_WIDTH - INT_WIDTH;
    localparam int NW         = DATA_WIDTH + FRAC_WIDTH;
    localparam int CW         = $clog2(NW);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // valid/ready never depend combinationally on the partner signal, only on FSM state.
    fsm_state_t r_state;
    fsm_state_t w_state_next;

    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [NW-1:0]         r_n;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_sign;
    logic                  r_dz;
    logic [DATA_WIDTH-1:0] r_q;
    logic                  r_dz_out;
    logic                  r_ovf;

    logic [DATA_WIDTH-1:0] w_abs_a;
    logic [DATA_WIDTH-1:0] w_abs_b;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_rem_next;
    logic [NW-1:0]         w_n_next;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_sat_q;
    logic                  w_sat_ovf;

    // Magnitudes stay unsigned, so |0x8000...0| = 2^(DATA_WIDTH-1) is represented exactly.
    assign w_abs_a = a[DATA_WIDTH-1] ? (-a) : a;
    assign w_abs_b = b[DATA_WIDTH-1] ? (-b) : b;

    // r_n shifts dividend bits out of the top and quotient bits in at the bottom.
    assign w_shift    = {r_rem, r_n[NW-1]};
    assign w_ge       = (w_shift >= {1'b0, r_b});
    assign w_diff     = w_shift - {1'b0, r_b};
    assign w_rem_next = w_ge ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
    assign w_n_next   = {r_n[NW-2:0], w_ge};
    assign w_last     = (r_cnt == CW'(NW - 1));

    my_div_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAG_WIDTH  (NW)
    ) u_sat (
        .magnitude   (w_n_next),
        .sign        (r_sign),
        .div_by_zero (r_dz),
        .q           (w_sat_q),
        .overflow    (w_sat_ovf)
    );

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = ST_CALC;
            end
            ST_CALC: begin
                if (r_dz || w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ADC_CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_n      <= '0;
            r_b      <= '0;
            r_sign   <= 1'b0;
            r_dz     <= 1'b0;
            r_q      <= '0;
            r_dz_out <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_n    <= {w_abs_a, {FRAC_WIDTH{1'b0}}};
                        r_b    <= w_abs_b;
                        r_rem  <= '0;
                        r_cnt  <= '0;
                        r_sign <= a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
                        r_dz   <= (b == '0);
                    end
                end
                ST_CALC: begin
                    if (!r_dz) begin
                        r_n   <= w_n_next;
                        r_rem <= w_rem_next;
                        r_cnt <= r_cnt + CW'(1);
                    end
                    // The final quotient bit feeds the saturator on the same edge it is formed.
                    if (r_dz || w_last) begin
                        r_q      <= w_sat_q;
                        r_dz_out <= r_dz;
                        r_ovf    <= w_sat_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q           = r_q;
    assign div_by_zero = r_dz_out;
    assign overflow    = r_ovf;
    assign dbg_state   = r_state;

endmodule
